// File: rtl/mem_access_unit.sv
// Byte-serial load/store sequencer for a byte-wide data memory (little-endian, address wrap).
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned half/word requests with resp_err.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [WORD_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [WORD_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BYTE_WIDTH-1:0] mem_wdata,
  input  logic [BYTE_WIDTH-1:0] mem_rdata
);

  localparam int LANES = WORD_WIDTH / BYTE_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [WORD_WIDTH-1:0]   wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0]   rbuf_q, rbuf_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [1:0]              last_q, last_d;
  logic [BYTE_WIDTH-1:0]   wlane [LANES];
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^req_addr[WORD_WIDTH-1:ADDR_WIDTH];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_wlane
    assign wlane[gi] = wdata_q[gi*BYTE_WIDTH +: BYTE_WIDTH];
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q, err_d;
  logic misaligned;
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      cnt_q   <= 2'b00;
      last_q  <= 2'b00;
`ifdef MEM_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
`ifdef MEM_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
`ifdef MEM_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          uns_d   = req_unsigned;
          base_d  = req_addr[ADDR_WIDTH-1:0];
          wdata_d = req_wdata;
          rbuf_d  = '0;   // cleared so stores and short loads report zeros in unused lanes
          cnt_d   = 2'd0;
          last_d  = (req_size == 2'b00) ? 2'd0 : (req_size == 2'b01) ? 2'd1 : 2'd3;
          state_d = ACCESS;
`ifdef MEM_ALIGN_CHECK_EN
          err_d = 1'b0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      ACCESS: begin
        if (!write_q) begin
          rbuf_d[cnt_q*BYTE_WIDTH +: BYTE_WIDTH] = mem_rdata;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
    // Gated by rst so a store aborted mid-way commits no byte in the reset cycle.
    mem_write  = (state_q == ACCESS) && write_q && !rst;
    mem_addr   = (state_q == ACCESS) ? base_q + ADDR_WIDTH'(cnt_q) : '0;
    mem_wdata  = ((state_q == ACCESS) && write_q) ? wlane[cnt_q] : '0;
    case (size_q)
      2'b00:   resp_rdata = {{(WORD_WIDTH-BYTE_WIDTH){rbuf_q[BYTE_WIDTH-1] & ~uns_q}},
                             rbuf_q[BYTE_WIDTH-1:0]};
      2'b01:   resp_rdata = {{(WORD_WIDTH-2*BYTE_WIDTH){rbuf_q[2*BYTE_WIDTH-1] & ~uns_q}},
                             rbuf_q[2*BYTE_WIDTH-1:0]};
      default: resp_rdata = rbuf_q;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    resp_err = (state_q == DONE) && err_q;
`else
    resp_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a 32-byte memory model.
// Honours MEM_ALIGN_CHECK_EN for the wrapped word-load case.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:31] = '{4: 8'h11, 5: 8'h22, 6: 8'h33, 7: 8'h84, default: 8'h00};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  mem_access_unit #(.ADDR_WIDTH(5), .BYTE_WIDTH(8), .WORD_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  // Issue one request from IDLE and check every cycle through DONE.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_size = 2'b00; req_unsigned = ~uns;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(mem_addr), (addr + 32'(i)) % 32);
      chk($sformatf("%s_we%0d", tag, i), 32'(mem_write), 32'(w));
      if (w) chk($sformatf("%s_wd%0d", tag, i), 32'(mem_wdata), (wd >> (8 * i)) & 32'hFF);
      chk($sformatf("%s_busy%0d", tag, i), 32'({req_ready, resp_valid}), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_done_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_done_we"}, 32'(mem_write), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'({resp_valid, resp_err, mem_write}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst = 1'b0;

    do_req("ld_w4",   1'b0, 2'b10, 1'b0, 32'd4, 32'h0, 32'h84332211);
    do_req("ld_b7s",  1'b0, 2'b00, 1'b0, 32'd7, 32'h0, 32'hFFFFFF84);
    do_req("ld_b7u",  1'b0, 2'b00, 1'b1, 32'd7, 32'h0, 32'h00000084);
    do_req("ld_h6s",  1'b0, 2'b01, 1'b0, 32'd6, 32'h0, 32'hFFFF8433);
    do_req("ld_h6u",  1'b0, 2'b01, 1'b1, 32'd6, 32'h0, 32'h00008433);
    do_req("ld_b4s",  1'b0, 2'b00, 1'b0, 32'd4, 32'h0, 32'h00000011);
    do_req("st_w8",   1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, 32'h0);
    chk("st_w8_mem", {mem[11], mem[10], mem[9], mem[8]}, 32'hDEADBEEF);
    do_req("ld_w8",   1'b0, 2'b11, 1'b1, 32'd8, 32'h0, 32'hDEADBEEF);
    do_req("st_b31",  1'b1, 2'b00, 1'b0, 32'h0000_001F, 32'h1234_565A, 32'h0);
    chk("st_b31_mem", 32'(mem[31]), 32'h5A);

`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd31;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mis_valid", 32'(resp_valid), 32'd1);
    chk("mis_err", 32'(resp_err), 32'd1);
    chk("mis_rdata", resp_rdata, 32'd0);
    chk("mis_we", 32'(mem_write), 32'd0);
    @(negedge clk);
    chk("mis_after", 32'({req_ready, resp_valid, resp_err}), 32'b100);
    chk("mis_mem", 32'(mem[31]), 32'h5A);
`else
    do_req("ld_w31",  1'b0, 2'b10, 1'b0, 32'd31, 32'h0, 32'h0000005A);
`endif

    // Store aborted by reset during its third byte.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'd12;
    req_wdata = 32'hAABBCCDD;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abt_we0", 32'(mem_write), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("abt_addr2", 32'(mem_addr), 32'd14);
    rst = 1'b1;
    #1;
    chk("abt_we_rst", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("abt_noresp", 32'(resp_valid), 32'd0);
    chk("abt_ready0", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("abt_ready1", 32'({req_ready, resp_valid, mem_write}), 32'b100);
    chk("abt_mem", {mem[15], mem[14], mem[13], mem[12]}, 32'h0000CCDD);

    // Continuous byte loads: one acceptance every three cycles.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b1;
    req_addr = 32'd5;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("b2b_ready%0d", k), 32'(req_ready), (k % 3 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_valid%0d", k), 32'(resp_valid), (k % 3 == 2) ? 32'd1 : 32'd0);
      if (k % 3 == 2) chk($sformatf("b2b_rdata%0d", k), resp_rdata, 32'h22);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_end_ready", 32'(req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
